jtframe_joyser: RTL

// - Parametrised serial joystick reader for boards with 74x165-style shift-register joystick adapters (NeptUNO, MC2+).
// - Generalises the fixed 2-port/6-bit reader to PORTS x BITS, with a programmable clock divider and inter-frame gap.
// - Adds an enable input, a frame_done strobe and optional debouncing.
// - Sits at the target top level, in front of the jtframe joystick bus.

---
 rtl/jtframe_joyser_pkg.sv | 21 ++
 rtl/jtframe_joyser_if.sv | 28 ++
 rtl/jtframe_joyser_deb.sv | 55 +++++
 rtl/jtframe_joyser.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/jtframe_joyser_pkg.sv
// Shared types and elaboration helpers for the serial joystick reader.
package jtframe_joyser_pkg;

  typedef enum logic [1:0] {
    ST_GAP   = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_LATCH = 2'd3
  } state_t;

  // Total number of serial bits in one frame.
  function automatic int unsigned frame_w(input int unsigned ports, input int unsigned bits);
    return ports * bits;
  endfunction

  // Width of a counter that must hold values 0..maxval.
  function automatic int unsigned cnt_w(input int unsigned maxval);
    return (maxval < 2) ? 1 : $clog2(maxval + 1);
  endfunction

endpackage

// File: rtl/jtframe_joyser_if.sv
// Joystick adapter bus plus the reader's control/result signals.
//   en, joy_data             : into the reader
//   joy_clk, joy_load        : adapter shift clock / active-low parallel load
//   joy_out [PORTS*BITS]     : latched buttons, active low, port 0 in the MSBs
//   frame_done               : 1-cycle strobe after each latch
interface jtframe_joyser_if #(
  parameter int unsigned PORTS = 2,
  parameter int unsigned BITS  = 6
);
  localparam int unsigned FW = PORTS * BITS;

  logic          en;
  logic          joy_data;
  logic          joy_clk;
  logic          joy_load;
  logic [FW-1:0] joy_out;
  logic          frame_done;

  modport master (
    input  en, joy_data,
    output joy_clk, joy_load, joy_out, frame_done
  );

  modport slave (
    output en, joy_data,
    input  joy_clk, joy_load, joy_out, frame_done
  );
endinterface

// File: rtl/jtframe_joyser_deb.sv
// Per-bit frame debouncer: an output bit flips only after DEBOUNCE
// consecutive updates that disagree with it.
//   clk, rst_n : clock, async active-low reset
//   upd        : one-cycle update strobe (frame latch)
//   din [W]    : freshly sampled frame
//   dout [W]   : debounced result, resets to all ones (released)
module jtframe_joyser_deb
  import jtframe_joyser_pkg::*;
#(
  parameter int unsigned W        = 12,
  parameter int unsigned DEBOUNCE = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         upd,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);
  localparam int unsigned CW = cnt_w(DEBOUNCE);

  logic [CW-1:0] cnt_q [W];
  logic [CW-1:0] cnt_d [W];
  logic [W-1:0]  dout_q, dout_d;

  // Counter clears on agreement; flips the bit on the DEBOUNCE-th disagreement.
  always_comb begin
    dout_d = dout_q;
    for (int i = 0; i < int'(W); i++) begin
      cnt_d[i] = cnt_q[i];
      if (upd) begin
        if (din[i] == dout_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CW'(DEBOUNCE - 1)) begin
          dout_d[i] = din[i];
          cnt_d[i]  = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= '1;
      for (int i = 0; i < int'(W); i++) cnt_q[i] <= '0;
    end else begin
      dout_q <= dout_d;
      for (int i = 0; i < int'(W); i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/jtframe_joyser.sv
// Serial reader for daisy-chained 74x165 joystick adapters.
// Loads the chain, shifts PORTS*BITS bits (port 0 first, MSB first),
// latches them into joy_out and idles GAP ticks between frames.
//   clk, rst_n : clock, async active-low reset
//   io         : jtframe_joyser_if.master (en, joy_data, joy_clk, joy_load,
//                joy_out, frame_done)
// Build option: JTFRAME_JOYSER_DEBOUNCE_EN routes the latch through a
// per-bit debouncer; otherwise joy_out takes each frame directly.
module jtframe_joyser
  import jtframe_joyser_pkg::*;
#(
  parameter int unsigned PORTS    = 2,
  parameter int unsigned BITS     = 6,
  parameter int unsigned CLKDIV   = 8,
  parameter int unsigned GAP      = 16,
  parameter int unsigned DEBOUNCE = 3
) (
  input  logic clk,
  input  logic rst_n,
  jtframe_joyser_if.master io
);
  localparam int unsigned FW          = frame_w(PORTS, BITS);
  localparam int unsigned SHIFT_TICKS = 2 * FW;
  localparam int unsigned CNT_MAX     = (SHIFT_TICKS > GAP) ? SHIFT_TICKS : GAP;
  localparam int unsigned CNT_W       = cnt_w(CNT_MAX);
  localparam int unsigned DIV_W       = cnt_w(CLKDIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             tick_c;
  logic [1:0]       sync_q, sync_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [FW-1:0]    sr_q, sr_d;
  logic             joy_clk_q, joy_clk_d;
  logic             joy_load_q, joy_load_d;
  logic             frame_done_q, frame_done_d;
  logic             latch_c;

  // Free-running tick divider and joy_data synchroniser.
  assign tick_c = (div_q == DIV_W'(CLKDIV - 1));
  assign latch_c = (state_q == ST_LATCH);

  always_comb begin
    div_d  = tick_c ? '0 : div_q + 1'b1;
    sync_d = {sync_q[0], io.joy_data};
  end

  // Frame sequencer. cnt_q counts gap ticks, load ticks or shift half-bits.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sr_d         = sr_q;
    joy_clk_d    = joy_clk_q;
    frame_done_d = 1'b0;
    case (state_q)
      ST_GAP: begin
        if (tick_c) begin
          if (io.en && (cnt_q >= CNT_W'(GAP - 1))) begin
            state_d = ST_LOAD;
            cnt_d   = '0;
          end else if (cnt_q < CNT_W'(GAP)) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_LOAD: begin
        if (tick_c) begin
          if (cnt_q == CNT_W'(1)) begin
            state_d = ST_SHIFT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        if (tick_c) begin
          // Even half-bit: rising edge, capture the bit the chain presents now.
          joy_clk_d = ~cnt_q[0];
          if (!cnt_q[0]) sr_d = {sr_q[FW-2:0], sync_q[1]};
          if (cnt_q == CNT_W'(SHIFT_TICKS - 1)) begin
            state_d = ST_LATCH;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_LATCH: begin
        state_d      = ST_GAP;
        cnt_d        = '0;
        frame_done_d = 1'b1;
      end
      default: begin
        state_d = ST_GAP;
        cnt_d   = '0;
      end
    endcase
    joy_load_d = (state_d != ST_LOAD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q        <= '0;
      sync_q       <= '1;
      state_q      <= ST_GAP;
      cnt_q        <= '0;
      sr_q         <= '1;
      joy_clk_q    <= 1'b0;
      joy_load_q   <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      div_q        <= div_d;
      sync_q       <= sync_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sr_q         <= sr_d;
      joy_clk_q    <= joy_clk_d;
      joy_load_q   <= joy_load_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign io.joy_clk    = joy_clk_q;
  assign io.joy_load   = joy_load_q;
  assign io.frame_done = frame_done_q;

`ifdef JTFRAME_JOYSER_DEBOUNCE_EN
  jtframe_joyser_deb #(
    .W        (FW),
    .DEBOUNCE (DEBOUNCE)
  ) u_deb (
    .clk   (clk),
    .rst_n (rst_n),
    .upd   (latch_c),
    .din   (sr_q),
    .dout  (io.joy_out)
  );
`else
  logic [FW-1:0] joy_out_q, joy_out_d;
  logic          unused_debounce;

  assign unused_debounce = ^32'(DEBOUNCE);

  always_comb joy_out_d = latch_c ? sr_q : joy_out_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) joy_out_q <= '1;
    else        joy_out_q <= joy_out_d;
  end

  assign io.joy_out = joy_out_q;
`endif

endmodule
